hist_eq_map: RTL

//   Histogram-equalisation mapping stage, downstream of hist_stat. Takes the cumulative

---
 rtl/hist_eq_map.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/hist_eq_map.sv
// Histogram-equalisation remap stage: turns the cumulative histogram of one frame into an
// 8-bit LUT (ping-pong banks) and remaps the following frame's gray stream through it.
module hist_eq_map #(
    parameter int IMG_WIDTH  = 32'd640,
    parameter int IMG_HEIGHT = 32'd480,
    parameter int FRAC_BITS  = 32'd24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        img_vsync,
    input  logic        img_href,
    input  logic [7:0]  img_gray,
    input  logic [7:0]  pixel_level,
    input  logic [19:0] pixel_level_acc_num,
    input  logic        pixel_level_valid,
    output logic        post_img_vsync,
    output logic        post_img_href,
    output logic [7:0]  post_img_gray,
    output logic        lut_ready
);

    localparam longint unsigned TOTAL   = 64'(IMG_WIDTH) * 64'(IMG_HEIGHT);
    localparam longint unsigned RECIP_L = ((64'd255 << FRAC_BITS) + (TOTAL / 64'd2)) / TOTAL;
    localparam int RECIP_W = $clog2(RECIP_L + 64'd1);
    localparam int PROD_W  = 32'd20 + RECIP_W;
    localparam int VAL_W   = PROD_W - FRAC_BITS + 32'd1;
    localparam logic [RECIP_W-1:0] RECIP = RECIP_W'(RECIP_L);
    localparam logic [PROD_W:0]    HALF  = (PROD_W + 1)'(64'd1 << (FRAC_BITS - 32'd1));

    logic [PROD_W-1:0] prod_r;
    logic [7:0]        lvl_c1_r;
    logic              vld_c1_r;
    logic [PROD_W:0]   rounded_s;
    logic [VAL_W-1:0]  val_s;
    logic [7:0]        map_val_s;

    logic              rd_bank_r;
    logic              table_done_r;
    logic              run_r;
    logic [7:0]        exp_lvl_r;
    logic              vsync_prev_r;
    logic              swap_s;
    logic              run_next_s;
    logic [7:0]        exp_next_s;
    logic              done_next_s;

    logic [7:0]        lut_mem [0:511];
    logic [7:0]        ram_q_r;
    logic              vsync_d1_r;
    logic              href_d1_r;
    logic [7:0]        gray_d1_r;
    logic              post_vsync_r;
    logic              post_href_r;
    logic [7:0]        post_gray_r;
    logic              lut_ready_r;
    logic [7:0]        post_gray_next_s;

    // Fill stage 1: scale the cumulative count by the fixed-point reciprocal of the frame size.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_r   <= {PROD_W{1'b0}};
            lvl_c1_r <= 8'd0;
            vld_c1_r <= 1'b0;
        end else begin
            prod_r   <= PROD_W'(pixel_level_acc_num) * PROD_W'(RECIP);
            lvl_c1_r <= pixel_level;
            vld_c1_r <= pixel_level_valid;
        end
    end

    // Fill stage 2: round to nearest integer and saturate to the 8-bit output range.
    always_comb begin
        rounded_s = {1'b0, prod_r} + HALF;
        val_s     = VAL_W'(rounded_s >> FRAC_BITS);
        if (val_s > VAL_W'(8'd255)) begin
            map_val_s = 8'd255;
        end else begin
            map_val_s = val_s[7:0];
        end
    end

    assign swap_s = img_vsync && !vsync_prev_r && table_done_r;

    // Run tracking: a table counts as complete only when levels 0..255 arrive back to back.
    always_comb begin
        run_next_s  = run_r;
        exp_next_s  = exp_lvl_r;
        done_next_s = table_done_r;
        if (swap_s) begin
            done_next_s = 1'b0;
        end else begin
            done_next_s = table_done_r;
        end
        if (vld_c1_r) begin
            if (lvl_c1_r == 8'd0) begin
                run_next_s  = 1'b1;
                exp_next_s  = 8'd1;
                done_next_s = 1'b0;
            end else if (run_r && (lvl_c1_r == exp_lvl_r)) begin
                if (lvl_c1_r == 8'd255) begin
                    run_next_s  = 1'b0;
                    done_next_s = 1'b1;
                end else begin
                    exp_next_s = exp_lvl_r + 8'd1;
                end
            end else begin
                run_next_s = 1'b0;
            end
        end else begin
            run_next_s = 1'b0;
        end
    end

    // Bank control: swap banks only at a frame start and only with a finished table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_bank_r    <= 1'b0;
            table_done_r <= 1'b0;
            run_r        <= 1'b0;
            exp_lvl_r    <= 8'd0;
            vsync_prev_r <= 1'b0;
            lut_ready_r  <= 1'b0;
        end else begin
            vsync_prev_r <= img_vsync;
            table_done_r <= done_next_s;
            run_r        <= run_next_s;
            exp_lvl_r    <= exp_next_s;
            if (swap_s) begin
                rd_bank_r   <= ~rd_bank_r;
                lut_ready_r <= 1'b1;
            end else begin
                rd_bank_r   <= rd_bank_r;
                lut_ready_r <= lut_ready_r;
            end
        end
    end

    // LUT RAM: fill writes the idle bank, the pixel path reads the active one.
    always_ff @(posedge clk) begin
        if (vld_c1_r) begin
            lut_mem[{~rd_bank_r, lvl_c1_r}] <= map_val_s;
        end
        ram_q_r <= lut_mem[{rd_bank_r, img_gray}];
    end

    // Pixel stage 1: delay the sync/valid/raw pixel alongside the RAM read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d1_r <= 1'b0;
            href_d1_r  <= 1'b0;
            gray_d1_r  <= 8'd0;
        end else begin
            vsync_d1_r <= img_vsync;
            href_d1_r  <= img_href;
            gray_d1_r  <= img_gray;
        end
    end

    // Blank pixels output 0; raw gray passes through until the first table is active.
    always_comb begin
        post_gray_next_s = 8'd0;
        if (!href_d1_r) begin
            post_gray_next_s = 8'd0;
        end else if (lut_ready_r) begin
            post_gray_next_s = ram_q_r;
        end else begin
            post_gray_next_s = gray_d1_r;
        end
    end

    // Pixel stage 2: registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_vsync_r <= 1'b0;
            post_href_r  <= 1'b0;
            post_gray_r  <= 8'd0;
        end else begin
            post_vsync_r <= vsync_d1_r;
            post_href_r  <= href_d1_r;
            post_gray_r  <= post_gray_next_s;
        end
    end

    assign post_img_vsync = post_vsync_r;
    assign post_img_href  = post_href_r;
    assign post_img_gray  = post_gray_r;
    assign lut_ready      = lut_ready_r;

endmodule
